// File: rtl/bmem_pkg.sv
// rtl/bmem_pkg.sv - shared constants, FSM state types and read-request type for the banked-memory responder
package bmem_pkg;

    localparam int BMEM_ADDR_W    = 32;
    localparam int BMEM_DATA_W    = 64;
    localparam int BMEM_BURST_LEN = 4;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_BURST
    } rd_state_t;

    typedef enum logic {
        W_IDLE,
        W_BEAT
    } wr_state_t;

    // Queued read request: the line-aligned address of the requested line.
    typedef struct packed {
        logic [BMEM_ADDR_W-1:0] addr;
    } bmem_rd_req_t;

endpackage

// File: rtl/bmem_req_fifo.sv
// rtl/bmem_req_fifo.sv - synchronous request FIFO with occupancy count, asynchronous active-high reset
module bmem_req_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bmem_responder.sv
// rtl/bmem_responder.sv - banked-memory burst responder; optional BMEM_RESPONDER_PROTOCOL_CHECK_EN enables sticky protocol error flag
module bmem_responder
    import bmem_pkg::*;
#(
    parameter int ADDR_W     = BMEM_ADDR_W,
    parameter int DATA_W     = BMEM_DATA_W,
    parameter int BURST_LEN  = BMEM_BURST_LEN,
    parameter int LINES      = 256,
    parameter int RD_LATENCY = 8,
    parameter int QDEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] bmem_addr,
    input  logic              bmem_read,
    input  logic              bmem_write,
    input  logic [DATA_W-1:0] bmem_wdata,
    output logic              bmem_ready,
    output logic [ADDR_W-1:0] bmem_raddr,
    output logic [DATA_W-1:0] bmem_rdata,
    output logic              bmem_rvalid,
    output logic              bmem_error
);

    localparam int OFF    = $clog2(BURST_LEN * DATA_W / 8);
    localparam int IDX_W  = $clog2(LINES);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int TMR_W  = $clog2(RD_LATENCY + 1);
    localparam int CNT_W  = $clog2(QDEPTH) + 1;

    logic [DATA_W-1:0] mem [LINES * BURST_LEN];

    logic              ready_en;
    wr_state_t         wr_state;
    wr_state_t         wr_state_nxt;
    logic [BEAT_W-1:0] wr_beat;
    logic [IDX_W-1:0]  wr_line;
    logic              wr_accept;
    logic              rd_accept;

    rd_state_t         rd_state;
    rd_state_t         rd_state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic              tmr_load;
    logic [BEAT_W-1:0] rd_beat;
    logic              rd_pop;

    logic [ADDR_W-1:0] head_addr;
    logic [IDX_W-1:0]  head_line;
    logic              q_full;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;

    assign bmem_ready = ready_en && (wr_state == W_IDLE) && !q_full;
    // A simultaneous read and write takes the write and drops the read.
    assign wr_accept  = bmem_write && bmem_ready;
    assign rd_accept  = bmem_read && !bmem_write && bmem_ready;
    assign head_line  = head_addr[OFF +: IDX_W];

    bmem_req_fifo #(
        .W     (ADDR_W),
        .DEPTH (QDEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_accept),
        .pop   (rd_pop),
        .din   ({bmem_addr[ADDR_W-1:OFF], {OFF{1'b0}}}),
        .dout  (head_addr),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Holds ready low during reset and releases it on the first edge afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Write FSM state, current beat and captured line index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_beat  <= '0;
            wr_line  <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            if (wr_accept) begin
                wr_beat <= BEAT_W'(1);
                wr_line <= bmem_addr[OFF +: IDX_W];
            end else if (wr_state == W_BEAT) begin
                wr_beat <= wr_beat + 1'b1;
            end
        end
    end

    // Write FSM next state: leave idle on accept, return after the last beat.
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE: if (wr_accept) wr_state_nxt = W_BEAT;
            W_BEAT: if (wr_beat == BEAT_W'(BURST_LEN - 1)) wr_state_nxt = W_IDLE;
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Line storage: beat 0 on accept, later beats while the write FSM is busy.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{bmem_addr[OFF +: IDX_W], BEAT_W'(0)}] <= bmem_wdata;
        end else if (wr_state == W_BEAT) begin
            mem[{wr_line, wr_beat}] <= bmem_wdata;
        end
    end

    // Read FSM state, latency timer and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            tmr      <= '0;
            rd_beat  <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            if (tmr_load) begin
                tmr <= TMR_W'(RD_LATENCY - 1);
            end else if ((rd_state == R_WAIT) && (tmr != '0)) begin
                tmr <= tmr - 1'b1;
            end
            rd_beat <= (rd_state == R_BURST) ? rd_beat + 1'b1 : '0;
        end
    end

    // Read FSM next state: a new head loads the timer on the edge it becomes head.
    always_comb begin
        rd_state_nxt = rd_state;
        tmr_load     = 1'b0;
        rd_pop       = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (rd_accept || !q_empty) begin
                    rd_state_nxt = R_WAIT;
                    tmr_load     = 1'b1;
                end
            end
            R_WAIT: begin
                if (tmr == '0) rd_state_nxt = R_BURST;
            end
            R_BURST: begin
                if (rd_beat == BEAT_W'(BURST_LEN - 1)) begin
                    rd_pop = 1'b1;
                    if ((q_count > CNT_W'(1)) || rd_accept) begin
                        rd_state_nxt = R_WAIT;
                        tmr_load     = 1'b1;
                    end else begin
                        rd_state_nxt = R_IDLE;
                    end
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Read beats are taken straight from storage so completed writes are visible.
    assign bmem_rvalid = (rd_state == R_BURST);
    assign bmem_rdata  = bmem_rvalid ? mem[{head_line, rd_beat}] : '0;
    assign bmem_raddr  = bmem_rvalid ? head_addr : '0;

`ifdef BMEM_RESPONDER_PROTOCOL_CHECK_EN
    logic err_q;
    logic err_now;

    // Violations seen this cycle; during write beats only write-high without read is legal.
    always_comb begin
        err_now = 1'b0;
        if (bmem_read && bmem_write) err_now = 1'b1;
        if ((wr_state == W_BEAT) && (!bmem_write || bmem_read)) err_now = 1'b1;
        if ((wr_state == W_IDLE) && (bmem_read || bmem_write)) begin
            if (bmem_addr[OFF-1:0] != '0) err_now = 1'b1;
            if (!bmem_ready) err_now = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_now) begin
            err_q <= 1'b1;
        end
    end

    assign bmem_error = err_q;
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^bmem_addr[OFF-1:0];
    assign bmem_error       = 1'b0;
`endif

endmodule

// File: tb/tb_bmem_responder.sv
// tb/tb_bmem_responder.sv - directed self-checking bench for bmem_responder
module tb_bmem_responder;

`ifdef BMEM_RESPONDER_PROTOCOL_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
    logic        bmem_error;

    int cyc;
    int passed;
    int total;
    int acc;
    int last;
    int nv;

    bmem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .bmem_error  (bmem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bmem_ready !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        check({tag, "_ready_wait"}, bmem_ready, 1'b1);
    endtask

    // Beat b of a line carries base + b*inc.
    task automatic write_line(input string tag, input logic [31:0] a, input logic [63:0] base,
                              input logic [63:0] inc, input logic with_read);
        wait_ready(tag);
        bmem_write = 1'b1;
        bmem_read  = with_read;
        bmem_addr  = a;
        for (int b = 0; b < 4; b++) begin
            bmem_wdata = base + 64'(b) * inc;
            step();
            bmem_read = 1'b0;
        end
        bmem_write = 1'b0;
    endtask

    task automatic read_req(input string tag, input logic [31:0] a, output int acc_cyc);
        wait_ready(tag);
        bmem_read = 1'b1;
        bmem_addr = a;
        step();
        bmem_read = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic expect_burst(input string tag, input logic [31:0] a, input logic [63:0] base,
                                input logic [63:0] inc, input int ref_cyc, input int lat,
                                output int last_cyc);
        int n = 0;
        while (bmem_rvalid !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        check({tag, "_lat"}, 64'(cyc - ref_cyc), 64'(lat));
        for (int b = 0; b < 4; b++) begin
            check({tag, "_rvalid"}, bmem_rvalid, 1'b1);
            check({tag, "_rdata"}, bmem_rdata, base + 64'(b) * inc);
            check({tag, "_raddr"}, bmem_raddr, a);
            last_cyc = cyc;
            step();
        end
    endtask

    task automatic count_rvalid(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (bmem_rvalid === 1'b1) seen++;
            step();
        end
    endtask

    initial begin
        cyc        = 0;
        passed     = 0;
        total      = 0;
        rst        = 1'b1;
        bmem_addr  = '0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;

        // Reset state.
        step();
        check("rst_ready", bmem_ready, 1'b0);
        check("rst_rvalid", bmem_rvalid, 1'b0);
        check("rst_rdata", bmem_rdata, 64'h0);
        check("rst_raddr", bmem_raddr, 32'h0);
        check("rst_error", bmem_error, 1'b0);
        rst = 1'b0;
        step();
        check("rst_release_ready", bmem_ready, 1'b1);

        // Write then read line 0x100; first beat 8 cycles after accept.
        write_line("w100", 32'h100, 64'h11, 64'h11, 1'b0);
        read_req("r100", 32'h100, acc);
        expect_burst("r100", 32'h100, 64'h11, 64'h11, acc, 8, last);
        check("r100_idle_rvalid", bmem_rvalid, 1'b0);
        check("r100_idle_rdata", bmem_rdata, 64'h0);
        check("r100_error", bmem_error, 1'b0);

        // Four queued reads: queue fills, bursts return in order.
        for (int i = 0; i < 4; i++) begin
            write_line("wq", 32'(i * 32), 64'hA000 + 64'(i * 32), 64'h1, 1'b0);
        end
        wait_ready("q");
        for (int i = 0; i < 4; i++) begin
            bmem_read = 1'b1;
            bmem_addr = 32'(i * 32);
            step();
            if (i == 0) acc = cyc;
        end
        bmem_read = 1'b0;
        check("q_full_ready", bmem_ready, 1'b0);
        expect_burst("q0", 32'h000, 64'hA000, 64'h1, acc, 8, last);
        check("q_ready_after_pop", bmem_ready, 1'b1);
        // Next head loads its timer on the edge that retires the previous last beat.
        expect_burst("q1", 32'h020, 64'hA020, 64'h1, last, 9, last);
        expect_burst("q2", 32'h040, 64'hA040, 64'h1, last, 9, last);
        expect_burst("q3", 32'h060, 64'hA060, 64'h1, last, 9, last);
        check("q_done_rvalid", bmem_rvalid, 1'b0);
        check("q_error", bmem_error, 1'b0);

        // Read and write together: write wins, read dropped.
        write_line("rw200", 32'h200, 64'hC0, 64'h1, 1'b1);
        count_rvalid(20, nv);
        check("rw_no_rvalid", 64'(nv), 64'h0);
        check("rw_error", bmem_error, ERR_EN);
        read_req("r200", 32'h200, acc);
        expect_burst("r200", 32'h200, 64'hC0, 64'h1, acc, 8, last);
        check("rw_error_sticky", bmem_error, ERR_EN);

        // Reset during the third beat of a burst.
        read_req("rrst", 32'h100, acc);
        nv = 0;
        while (bmem_rvalid !== 1'b1 && nv < 64) begin
            step();
            nv++;
        end
        step();
        step();
        check("rrst_beat2", bmem_rdata, 64'h33);
        rst = 1'b1;
        #1;
        check("rrst_rvalid", bmem_rvalid, 1'b0);
        check("rrst_ready", bmem_ready, 1'b0);
        check("rrst_rdata", bmem_rdata, 64'h0);
        check("rrst_raddr", bmem_raddr, 32'h0);
        check("rrst_error", bmem_error, 1'b0);
        step();
        rst = 1'b0;
        step();
        check("rrst_release_ready", bmem_ready, 1'b1);
        count_rvalid(20, nv);
        check("rrst_no_stale", 64'(nv), 64'h0);

        // Aliasing: 0x40 and 0x4040 share line index 2.
        write_line("wa1", 32'h40, 64'h5000, 64'h1, 1'b0);
        write_line("wa2", 32'h4040, 64'h6000, 64'h1, 1'b0);
        read_req("ra", 32'h40, acc);
        expect_burst("ra", 32'h40, 64'h6000, 64'h1, acc, 8, last);
        check("ra_error", bmem_error, 1'b0);

        // Misaligned read returns the containing line.
        read_req("r104", 32'h104, acc);
        expect_burst("r104", 32'h100, 64'h11, 64'h11, acc, 8, last);
        check("r104_error", bmem_error, ERR_EN);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
